// File: rtl/demux_router.sv
// demux_router: registered 1-to-NCH demultiplexer with per-channel holding registers.
//
// Steers one WIDTH-bit word per cycle to the output channel chosen by in_sel. Each channel
// holds one word behind a valid/ready handshake, so consumers stall independently. Words
// addressed to a select >= NCH are always accepted, discarded and counted in a saturating
// drop counter.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    word to route
//   in_sel     destination channel index
//   in_valid   in_data/in_sel valid this cycle
//   in_ready   word accepted this cycle (combinational from in_sel and out_ready)
//   out_data   channel k at bits [k*WIDTH +: WIDTH]; stale data stays visible when empty
//   out_valid  bit k: channel k holds an undelivered word
//   out_ready  bit k: consumer k takes the word this cycle
//   drop_cnt   saturating count of words dropped for an illegal select

module demux_router #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NCH   = 9,
    parameter int unsigned CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [3:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [CNTW-1:0]      drop_cnt
);

    logic [NCH*WIDTH-1:0] data_q, data_d;
    logic [NCH-1:0]       valid_q, valid_d;
    logic [CNTW-1:0]      drop_q, drop_d;

    logic [NCH-1:0] sel_hit;
    logic [NCH-1:0] slot_free;
    logic [NCH-1:0] load;
    logic           legal;
    logic           accept;
    logic           drop;

    // One-hot decode of the select; an all-zero result means the select is illegal.
    always_comb begin
        sel_hit = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            sel_hit[k] = (32'(in_sel) == k);
        end
    end

    assign legal     = |sel_hit;
    // A slot can take a word if it is empty or its current word leaves this cycle.
    assign slot_free = ~valid_q | out_ready;
    assign in_ready  = ~legal | (|(sel_hit & slot_free));
    assign accept    = in_valid & in_ready;
    assign load      = sel_hit & {NCH{accept}};
    assign drop      = accept & ~legal;

    always_comb begin
        data_d = data_q;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (load[k]) begin
                data_d[k*WIDTH +: WIDTH] = in_data;
            end
        end
    end

    // Load wins over delivery, so a simultaneous deliver+load keeps the slot full.
    assign valid_d = (valid_q & ~out_ready) | load;

    always_comb begin
        drop_d = drop_q;
        if (drop && (drop_q != {CNTW{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= '0;
            drop_q  <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: directed self-checking bench for demux_router (WIDTH=16, NCH=9, CNTW=8).

module tb_demux_router;

    logic          clk;
    logic          rst_n;
    logic [15:0]   in_data;
    logic [3:0]    in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [143:0]  out_data;
    logic [8:0]    out_valid;
    logic [8:0]    out_ready;
    logic [7:0]    drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    demux_router #(
        .WIDTH (16),
        .NCH   (9),
        .CNTW  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] slice(input int k);
        return out_data[k*16 +: 16];
    endfunction

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = '0;
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if (out_valid !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_valid: got %h want %h", out_valid, 9'h000);
        end
        n_checks++;
        if (out_data !== 144'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", out_data);
        end
        n_checks++;
        if (drop_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_drop: got %h want %h", drop_cnt, 8'h00);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int k = 0; k < 9; k++) begin
            in_sel    = 4'(k);
            in_data   = 16'(k + 1);
            in_valid  = 1'b1;
            out_ready = '0;
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_ready[%0d]: got %b want 1", k, in_ready);
            end
            cycle();
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 9'h1FF) begin
            n_fail++;
            $display("FAIL fill_valid: got %h want %h", out_valid, 9'h1FF);
        end
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (slice(k) !== 16'(k + 1)) begin
                n_fail++;
                $display("FAIL fill_slice[%0d]: got %h want %h", k, slice(k), 16'(k + 1));
            end
        end
    endtask

    task automatic test_backpressure();
        // Drain only channel 4 so it is empty while channel 3 stays full.
        out_ready = 9'h010;
        cycle();
        out_ready = '0;
        in_sel    = 4'd3;
        in_data   = 16'hBEEF;
        in_valid  = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_full: got %b want 0", in_ready);
        end
        cycle();
        n_checks++;
        if (slice(3) !== 16'h0004) begin
            n_fail++;
            $display("FAIL bp_slice3_held: got %h want %h", slice(3), 16'h0004);
        end
        n_checks++;
        if (out_valid !== 9'h1EF) begin
            n_fail++;
            $display("FAIL bp_valid: got %h want %h", out_valid, 9'h1EF);
        end
        // in_ready must not depend on in_valid.
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_novalid: got %b want 0", in_ready);
        end
        in_sel = 4'd4;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_other: got %b want 1", in_ready);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        out_ready = 9'h008;
        in_sel    = 4'd3;
        in_data   = 16'hBEEF;
        in_valid  = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pt_ready: got %b want 1", in_ready);
        end
        cycle();
        n_checks++;
        if (out_valid[3] !== 1'b1 || slice(3) !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL pt_slice3: got v=%b d=%h want v=1 d=%h", out_valid[3], slice(3),
                     16'hBEEF);
        end
        in_data = 16'h1234;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got %b want 1", in_ready);
        end
        cycle();
        in_valid  = 1'b0;
        out_ready = '0;
        #1;
        n_checks++;
        if (out_valid !== 9'h1EF || slice(3) !== 16'h1234) begin
            n_fail++;
            $display("FAIL b2b_slice3: got v=%h d=%h want v=%h d=%h", out_valid, slice(3),
                     9'h1EF, 16'h1234);
        end
    endtask

    task automatic test_drain();
        logic [15:0] exp [9];
        exp = '{16'h1, 16'h2, 16'h3, 16'h1234, 16'h5, 16'h6, 16'h7, 16'h8, 16'h9};
        in_valid  = 1'b0;
        in_data   = 16'hFFFF;
        out_ready = 9'h1FF;
        cycle();
        out_ready = '0;
        #1;
        n_checks++;
        if (out_valid !== 9'h000) begin
            n_fail++;
            $display("FAIL drain_valid: got %h want %h", out_valid, 9'h000);
        end
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (slice(k) !== exp[k]) begin
                n_fail++;
                $display("FAIL drain_slice[%0d]: got %h want %h", k, slice(k), exp[k]);
            end
        end
    endtask

    task automatic test_illegal();
        int bad_ready;
        bad_ready = 0;
        in_sel    = 4'd2;
        in_data   = 16'hAAAA;
        in_valid  = 1'b1;
        out_ready = '0;
        cycle();
        for (int i = 0; i < 7; i++) begin
            in_sel  = 4'(9 + i);
            in_data = 16'(16'h5500 + i);
            #1;
            if (in_ready !== 1'b1) bad_ready++;
            cycle();
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (bad_ready != 0) begin
            n_fail++;
            $display("FAIL illegal_ready: got %0d low cycles want 0", bad_ready);
        end
        n_checks++;
        if (drop_cnt !== 8'd7) begin
            n_fail++;
            $display("FAIL illegal_drop7: got %0d want 7", drop_cnt);
        end
        n_checks++;
        if (out_valid !== 9'h004 || slice(2) !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL illegal_state: got v=%h d2=%h want v=%h d2=%h", out_valid, slice(2),
                     9'h004, 16'hAAAA);
        end
    endtask

    task automatic test_saturate();
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_sel = 4'(9 + (i % 7));
            cycle();
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (drop_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL drop_saturate: got %0d want 255", drop_cnt);
        end
    endtask

    task automatic test_async_reset();
        out_ready = '0;
        in_valid  = 1'b1;
        for (int k = 0; k < 9; k++) begin
            in_sel  = 4'(k);
            in_data = 16'(16'h0100 + k);
            cycle();
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 9'h1FF) begin
            n_fail++;
            $display("FAIL ar_prefill: got %h want %h", out_valid, 9'h1FF);
        end
        // Mid-cycle reset: checks land well before the next rising edge.
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 9'h000 || out_data !== 144'h0 || drop_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL ar_clear: got v=%h d=%h c=%h want all zero", out_valid, out_data,
                     drop_cnt);
        end
        #1 rst_n = 1'b1;
        cycle();
        in_sel   = 4'd0;
        in_data  = 16'h5A5A;
        in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 9'h000) begin
            n_fail++;
            $display("FAIL ar_pre_accept: got r=%b v=%h want r=1 v=%h", in_ready, out_valid,
                     9'h000);
        end
        cycle();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 9'h001 || slice(0) !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL ar_first_word: got v=%h d0=%h want v=%h d0=%h", out_valid, slice(0),
                     9'h001, 16'h5A5A);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_backpressure();
        test_back_to_back();
        test_drain();
        test_illegal();
        test_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
